// File: rtl/cache_arbiter.sv
// Round-robin arbiter/sequencer between NREQ requesters and one shared cache.
// One transaction at a time, with a watchdog that aborts a hung cache access.
module cache_arbiter #(
    parameter int WIDTH     = 8,
    parameter int RAM_DEPTH = 256,
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*$clog2(RAM_DEPTH)-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    rsp_err,
    output logic                    cache_re,
    output logic                    cache_we,
    output logic [$clog2(RAM_DEPTH)-1:0] cache_addr,
    output logic [WIDTH-1:0]        cache_wdata,
    input  logic                    cache_done,
    input  logic [WIDTH-1:0]        cache_rdata,
    output logic                    busy
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr, gnt_idx, cur_idx, cand;
    logic [IW:0]     sum;
    logic            gnt_found, cur_we, sel_we, to_hit;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   sel_addr;
    logic [WIDTH-1:0] sel_wdata;

    // Scan from rr_ptr upward, wrapping modulo NREQ; first pending requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ))
                sum = sum - (IW+1)'(NREQ);
            cand = sum[IW-1:0];
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // The accept pulse must track the live req_valid, so it is decoded from state.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && gnt_found)
            req_ready[gnt_idx] = 1'b1;
    end

    assign to_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cache_done || to_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            cur_idx     <= '0;
            cur_we      <= 1'b0;
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            cache_re    <= 1'b0;
            cache_we    <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            busy        <= 1'b0;
        end else begin
            cache_re  <= 1'b0;
            cache_we  <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: if (gnt_found) begin
                    cur_idx     <= gnt_idx;
                    cur_we      <= sel_we;
                    cache_addr  <= sel_addr;
                    cache_wdata <= sel_wdata;
                    cache_re    <= !sel_we;
                    cache_we    <= sel_we;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CW'(1);
                    // done beats a coincident timeout
                    if (cache_done) begin
                        rsp_valid[cur_idx] <= 1'b1;
                        rsp_rdata <= cur_we ? '0 : cache_rdata;
                    end else if (to_hit) begin
                        rsp_valid[cur_idx] <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: rr_ptr <= (cur_idx == IW'(NREQ - 1)) ? '0 : cur_idx + IW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized traffic against
// a transaction-level timing model of the arbiter.
module tb_cache_arbiter;
    localparam int WIDTH = 8, RAM_DEPTH = 256, NREQ = 2, TIMEOUT = 8, AW = 8;

    logic clk = 0, rst_n = 0;
    logic [NREQ-1:0] req_valid = '0, req_we = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*WIDTH-1:0] req_wdata = '0;
    logic [NREQ-1:0] req_ready, rsp_valid;
    logic [WIDTH-1:0] rsp_rdata, cache_wdata, cache_rdata = '0;
    logic rsp_err, cache_re, cache_we, busy, cache_done = 0;
    logic [AW-1:0] cache_addr;

    cache_arbiter #(.WIDTH(WIDTH), .RAM_DEPTH(RAM_DEPTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cache_re(cache_re), .cache_we(cache_we), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_done(cache_done), .cache_rdata(cache_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int model_ptr = 0;
    logic [WIDTH-1:0] last_rdata = '0;
    logic pend_we [NREQ];
    logic [AW-1:0] pend_addr [NREQ];
    logic [WIDTH-1:0] pend_wd [NREQ];

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        pend_we[i] = we; pend_addr[i] = a; pend_wd[i] = d;
        req_valid[i] = 1'b1; req_we[i] = we;
        req_addr[i*AW +: AW] = a; req_wdata[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic set_rand_req(input int i);
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), WIDTH'($urandom));
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests driven; returns at
    // posedge+1 of the IDLE cycle following the response.
    task automatic serve_one(input int dly, input logic [WIDTH-1:0] crd, input logic [NREQ-1:0] keep, output int t_acc);
        int waited, g, r;
        logic ewe, eerr;
        logic [AW-1:0] ea;
        logic [WIDTH-1:0] ed, erd;
        logic [NREQ-1:0] oh;
        waited = 0; t_acc = -1;
        #1;
        while (req_ready == '0 && waited < 12) begin
            @(posedge clk); #2; waited++;
        end
        checks++;
        if (req_ready == '0) begin
            $display("FAIL accept_timeout: req_ready=%b required a grant", req_ready);
            errors++;
            return;
        end
        g = model_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(model_ptr + k) % NREQ]) begin g = (model_ptr + k) % NREQ; break; end
        end
        oh = '0; oh[g] = 1'b1;
        if (req_ready !== oh || busy !== 1'b0) begin
            $display("FAIL grant: req_ready=%b busy=%b required %b busy=0", req_ready, busy, oh);
            errors++;
        end
        t_acc = cyc;
        ewe = pend_we[g]; ea = pend_addr[g]; ed = pend_wd[g];
        @(posedge clk); #1;
        if (keep[g]) set_rand_req(g); else req_valid[g] = 1'b0;
        cache_done = (dly == 0);
        cache_rdata = (dly == 0) ? crd : WIDTH'($urandom);
        #1;
        checks++;
        if (cache_re !== !ewe || cache_we !== ewe || cache_addr !== ea || cache_wdata !== ed ||
            busy !== 1'b1 || rsp_valid !== '0 || req_ready !== '0) begin
            $display("FAIL issue: re=%b we=%b addr=%h wdata=%h busy=%b rsp=%b required re=%b we=%b addr=%h wdata=%h busy=1 rsp=0",
                     cache_re, cache_we, cache_addr, cache_wdata, busy, rsp_valid, !ewe, ewe, ea, ed);
            errors++;
        end
        if (dly >= 1 && dly <= TIMEOUT) begin
            r = dly + 1; eerr = 1'b0; erd = ewe ? '0 : crd;
        end else begin
            r = TIMEOUT + 1; eerr = 1'b1; erd = '0;
        end
        for (int k = 1; k <= r; k++) begin
            @(posedge clk); #1;
            cache_done = (k == dly);
            cache_rdata = (k == dly) ? crd : WIDTH'($urandom);
            #1;
            checks++;
            if (k < r) begin
                if (rsp_valid !== '0 || rsp_err !== 1'b0 || cache_re !== 1'b0 || cache_we !== 1'b0 ||
                    busy !== 1'b1 || cache_addr !== ea || cache_wdata !== ed || rsp_rdata !== last_rdata ||
                    req_ready !== '0) begin
                    $display("FAIL wait_hold k=%0d: rsp=%b err=%b re=%b we=%b busy=%b addr=%h rdata=%h required rsp=0 err=0 re=0 we=0 busy=1 addr=%h rdata=%h",
                             k, rsp_valid, rsp_err, cache_re, cache_we, busy, cache_addr, rsp_rdata, ea, last_rdata);
                    errors++;
                end
            end else begin
                if (rsp_valid !== oh || rsp_err !== eerr || rsp_rdata !== erd || busy !== 1'b1 ||
                    cache_addr !== ea || cache_wdata !== ed) begin
                    $display("FAIL response: rsp=%b err=%b rdata=%h busy=%b required rsp=%b err=%b rdata=%h busy=1",
                             rsp_valid, rsp_err, rsp_rdata, busy, oh, eerr, erd);
                    errors++;
                end
                last_rdata = erd;
            end
        end
        @(posedge clk); #1;
        cache_done = 1'b0;
        model_ptr = (g + 1) % NREQ;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
            cache_re !== 1'b0 || cache_we !== 1'b0 || cache_addr !== '0 || cache_wdata !== '0 || busy !== 1'b0) begin
            $display("FAIL %s: ready=%b rsp=%b rdata=%h err=%b re=%b we=%b addr=%h wdata=%h busy=%b required all 0",
                     name, req_ready, rsp_valid, rsp_rdata, rsp_err, cache_re, cache_we, cache_addr, cache_wdata, busy);
            errors++;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        set_req(0, 1'b0, 8'h11, 8'h22);
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset_state");
        req_valid = '0;
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read;
        int t;
        set_req(0, 1'b0, 8'h15, 8'h00);
        serve_one(2, 8'hA5, 2'b00, t);
    endtask

    task automatic test_write;
        int t;
        set_req(1, 1'b1, 8'hF0, 8'h3C);
        serve_one(3, 8'h77, 2'b00, t);
    endtask

    task automatic test_round_robin;
        int t, prev;
        prev = -1;
        set_rand_req(0); set_rand_req(1);
        for (int i = 0; i < 6; i++) begin
            serve_one(1, WIDTH'($urandom), 2'b11, t);
            if (prev >= 0) begin
                checks++;
                if (t - prev != 4) begin
                    $display("FAIL rr_spacing: %0d cycles between accepts, required 4", t - prev);
                    errors++;
                end
            end
            prev = t;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout;
        int t;
        set_rand_req(0);
        serve_one(1000, 8'h5A, 2'b00, t);
        set_req(1, 1'b0, 8'h42, 8'h00);
        serve_one(1, 8'hC3, 2'b00, t);
    endtask

    task automatic test_boundary;
        int t;
        set_req(0, 1'b0, 8'h08, 8'h00);
        serve_one(TIMEOUT, 8'h9E, 2'b00, t);
        set_req(1, 1'b0, 8'h09, 8'h00);
        serve_one(0, 8'hE1, 2'b00, t);
        set_req(0, 1'b0, 8'h0A, 8'h00);
        serve_one(TIMEOUT + 1, 8'h66, 2'b00, t);
    endtask

    task automatic test_stray_idle;
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            cache_done = (k == 1);
            cache_rdata = WIDTH'($urandom);
            #1;
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0 || cache_re !== 1'b0 || cache_we !== 1'b0 || req_ready !== '0) begin
                $display("FAIL stray_idle: rsp=%b busy=%b re=%b we=%b ready=%b required all 0",
                         rsp_valid, busy, cache_re, cache_we, req_ready);
                errors++;
            end
            @(posedge clk); #1;
        end
        cache_done = 1'b0;
    endtask

    task automatic test_random;
        int t;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) set_rand_req(i);
            if (req_valid == '0) set_rand_req(int'($urandom_range(0, NREQ - 1)));
            serve_one(int'($urandom_range(0, TIMEOUT + 2)), WIDTH'($urandom), NREQ'($urandom), t);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid;
        int t;
        set_rand_req(0);
        serve_one(2, WIDTH'($urandom), 2'b00, t);
        set_req(1, 1'b0, 8'h33, 8'h00);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            $display("FAIL pre_reset_grant: req_ready=%b required 10", req_ready);
            errors++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check_all_zero("reset_mid_txn");
        @(posedge clk); #1;
        rst_n = 1;
        model_ptr = 0;
        last_rdata = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (rsp_valid !== '0 || busy !== 1'b0 || cache_re !== 1'b0 || cache_we !== 1'b0) begin
                $display("FAIL post_reset_quiet: rsp=%b busy=%b re=%b we=%b required all 0",
                         rsp_valid, busy, cache_re, cache_we);
                errors++;
            end
            @(posedge clk); #1;
        end
        set_rand_req(0); set_rand_req(1);
        serve_one(1, WIDTH'($urandom), 2'b00, t);
        req_valid = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_boundary();
        test_stray_idle();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Round-robin arbiter and sequencer placed between NREQ independent requesters and one shared cache (cache_top). It accepts one request at a time through a valid/ready handshake, issues it to the cache as a single-cycle re/we pulse with address and data held stable, waits for the cache's done, and returns read data (or a timeout error) to the granted requester. It adds a watchdog so a hung cache or RAM cannot stall every requester.

## Interface
- WIDTH, 8, data width; matches the cache.
- RAM_DEPTH, 256, address space; AW = $clog2(RAM_DEPTH).
- NREQ, 2, number of requesters (≥2); IW = $clog2(NREQ).
- TIMEOUT, 64, maximum WAIT cycles before the transaction is aborted (≥4).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock.
- req_valid  in  NREQ  per-requester request pending.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*WIDTH  flattened write data; requester i at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  NREQ  one-hot, 1-cycle completion pulse.
- rsp_rdata  out  WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- cache_re, cache_we  out  1  single-cycle command pulses to the cache.
- cache_addr  out  AW  held for the whole transaction.
- cache_wdata  out  WIDTH  held for the whole transaction.
- cache_done  in  1  cache completion.
- cache_rdata  in  WIDTH  cache data_out, sampled when cache_done is high.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is high, grant the first set bit found by scanning from rr_ptr upward, wrapping modulo NREQ. Assert req_ready[grant] in that cycle, latch grant index, we, addr and wdata, then go to ISSUE.
- ISSUE: assert cache_we (if latched we=1) or cache_re (if we=0) for exactly one cycle. Clear the watchdog counter and go to WAIT.
- WAIT: increment the counter each cycle.
  - cache_done=1: capture cache_rdata and set err=0, then go to RESP.
  - counter = TIMEOUT-1 without done: set err=1 and rdata=0, then go to RESP.
  - If done and timeout coincide, done wins (err=0).
- RESP: pulse rsp_valid[grant] with rsp_rdata and rsp_err. Set rr_ptr = (grant+1) mod NREQ, then go to IDLE.
- Write responses carry rsp_rdata = 0.
- A requester must hold req_valid, req_we, req_addr and req_wdata stable until req_ready. Dropping valid before accept is legal and produces no transaction.
- Requests arriving while busy stay pending. They are arbitrated on the next IDLE cycle.
- cache_done outside WAIT is ignored. This includes done asserted during ISSUE.
- At most one outstanding cache transaction at any time. cache_re and cache_we are never high together.
- Outputs are registered.
  - rsp_rdata holds its last value between responses.
  - rsp_err is 0 outside RESP.
- Reset values: state IDLE, rr_ptr 0, counter 0, and every output 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, cache_re, cache_we, cache_addr, cache_wdata, busy).
- Reset mid-transaction aborts the transaction. No response is ever issued for it, and cache command pulses stop immediately.

## Timing
- Accept cycle T: req_ready high.
- T+1: cache_re or cache_we high, addr and wdata valid.
- WAIT starts at T+2. cache_done observed at cycle D ≥ T+2 gives rsp_valid at D+1.
- Minimum latency, accept to response: 3 cycles.
- Next accept at the earliest the cycle after RESP, so the minimum spacing between accepts is 4 cycles.
- Timeout: done absent in cycles T+2 through T+1+TIMEOUT gives rsp_valid with rsp_err=1 at T+2+TIMEOUT.
- busy is high from T+1 through RESP, inclusive.

## Test plan
- Single read, NREQ=2: requester 0 reads addr 0x15, cache_done 2 cycles after cache_re with cache_rdata 0xA5 → req_ready[0] at T, cache_re at T+1, rsp_valid[0] with rdata 0xA5 and err 0 at T+4.
- Round-robin: both requesters hold valid continuously, each issuing 3 requests, done returned after 1 cycle → grant order 0,1,0,1,0,1; accepts exactly 4 cycles apart.
- Write: requester 1 writes 0x3C to addr 0xF0 → cache_we pulses for exactly 1 cycle, cache_addr 0xF0 and cache_wdata 0x3C held until RESP, rsp_valid[1] with rdata 0, cache_re never asserted.
- Timeout: TIMEOUT=8, cache_done never asserted → rsp_valid with rsp_err=1 exactly 10 cycles after accept, FSM returns to IDLE, next request is served normally.
- Boundary/stray: done coincides with the last timeout cycle → err=0; cache_done pulsed while IDLE or in ISSUE → ignored, no response generated.
- Reset: assert rst_n=0 during WAIT → all outputs 0 asynchronously; after release, no stale rsp_valid appears and requester 0 is granted first.
